// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch (IF) and data (DM).
// Data wins contention unless fetch has lost STARVE_MAX consecutive contended grants.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic          if_flush_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ack_o,
    output logic          if_stall_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_ack_o,
    output logic          dm_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER} state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          flush_pend_q, flush_pend_d;
    logic [SW-1:0] starve_q, starve_d;

    logic if_elig, dm_elig, grant_if, grant_dm;

    // A requester whose ack is high is still holding last cycle's request; mask it.
    assign if_elig  = if_req_i & ~if_flush_i & ~if_ack_q;
    assign dm_elig  = dm_req_i & ~dm_ack_q;
    assign grant_dm = (state_q == IDLE) & dm_elig & (~if_elig | (starve_q != STARVE_LIM));
    assign grant_if = (state_q == IDLE) & if_elig & ~grant_dm;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        flush_pend_d = flush_pend_q;
        starve_d     = starve_q;

        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = DM_XFER;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (grant_if) begin
                    state_d    = IF_XFER;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                end
            end
            IF_XFER: begin
                if (mem_ready_i) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    flush_pend_d = 1'b0;
                    // A flushed fetch still has to finish on the bus, but its data is dropped.
                    if (!flush_pend_q && !if_flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end
                end else if (if_flush_i) begin
                    flush_pend_d = 1'b1;
                end
            end
            DM_XFER: begin
                if (mem_ready_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req_i || grant_if) begin
            starve_d = '0;
        end else if (grant_dm && !if_flush_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            flush_pend_q <= flush_pend_d;
            starve_q     <= starve_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign if_stall_o  = if_req_i & ~if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign dm_stall_o  = dm_req_i & ~dm_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    localparam int SMAX     = 4;
    localparam int OWN_NONE = 0;
    localparam int OWN_IF   = 1;
    localparam int OWN_DM   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, dm_req, dm_we, mem_ready;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_ack_o, if_stall_o, dm_ack_o, dm_stall_o, mem_req_o, mem_we_o;

    int total = 0;
    int bad   = 0;

    // Model: who owns the bus, the latched transaction, and what each requester has seen.
    int          m_own, m_starve;
    logic        m_pend, m_mreq, m_mwe, m_ifa, m_dma;
    logic [15:0] m_maddr, m_mwdata, m_ifr, m_dmr;

    logic [15:0] gq[$];
    logic        prev_req;
    logic [15:0] exp_g [11] = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h1000,
                                16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h1000, 16'h2000};
    logic        ifa_now, dma_now, fl_now;

    mem_arbiter #(.AW(16), .DW(16), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_own = OWN_NONE; m_starve = 0; m_pend = 0; m_mreq = 0; m_mwe = 0;
        m_ifa = 0; m_dma = 0; m_maddr = 0; m_mwdata = 0; m_ifr = 0; m_dmr = 0;
    endtask

    task automatic model_step();
        bit ie, de, gi, gd, n_ifa, n_dma;
        n_ifa = 0; n_dma = 0; gi = 0; gd = 0;
        ie = if_req && !if_flush && !m_ifa;
        de = dm_req && !m_dma;
        if (m_own == OWN_NONE) begin
            gd = de && (!ie || m_starve != SMAX);
            gi = ie && !gd;
            if (gd) begin
                m_own = OWN_DM; m_mreq = 1; m_mwe = dm_we; m_maddr = dm_addr; m_mwdata = dm_wdata;
            end else if (gi) begin
                m_own = OWN_IF; m_mreq = 1; m_mwe = 0; m_maddr = if_addr;
            end
        end else if (mem_ready) begin
            if (m_own == OWN_IF) begin
                if (!m_pend && !if_flush) begin n_ifa = 1; m_ifr = mem_rdata; end
                m_pend = 0;
            end else begin
                n_dma = 1;
                if (!m_mwe) m_dmr = mem_rdata;
            end
            m_own = OWN_NONE; m_mreq = 0; m_mwe = 0;
        end else if (m_own == OWN_IF && if_flush) begin
            m_pend = 1;
        end
        if (!if_req || gi) m_starve = 0;
        else if (gd && !if_flush && m_starve < SMAX) m_starve++;
        m_ifa = n_ifa;
        m_dma = n_dma;
    endtask

    task automatic sample();
        @(negedge clk);
        chk("mem_req", mem_req_o, m_mreq);
        if (m_mreq) begin
            chk("mem_addr", mem_addr_o, m_maddr);
            chk("mem_we", mem_we_o, m_mwe);
        end
        if (m_mreq && m_mwe) chk("mem_wdata", mem_wdata_o, m_mwdata);
        chk("if_ack", if_ack_o, m_ifa);
        chk("dm_ack", dm_ack_o, m_dma);
        chk("if_rdata", if_rdata_o, m_ifr);
        chk("dm_rdata", dm_rdata_o, m_dmr);
        chk("if_stall", if_stall_o, if_req & ~m_ifa);
        chk("dm_stall", dm_stall_o, dm_req & ~m_dma);
        if (mem_req_o && !prev_req) gq.push_back(mem_addr_o);
        prev_req = mem_req_o;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; if_req = 0; if_addr = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ready = 0; prev_req = 0;
        model_reset();
        #12;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_ack", if_ack_o, 0);
        chk("rst_dm_ack", dm_ack_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // single zero-wait fetch
        if_req = 1; if_addr = 16'h0010; mem_ready = 1; mem_rdata = 16'hA5A5;
        sample(); chk("sf_stall_c0", if_stall_o, 1); chk("sf_req_c0", mem_req_o, 0); advance();
        sample(); chk("sf_req_c1", mem_req_o, 1); chk("sf_addr_c1", mem_addr_o, 16'h0010);
        chk("sf_we_c1", mem_we_o, 0); chk("sf_stall_c1", if_stall_o, 1); advance();
        sample(); chk("sf_ack_c2", if_ack_o, 1); chk("sf_rdata_c2", if_rdata_o, 16'hA5A5);
        chk("sf_stall_c2", if_stall_o, 0); advance();
        if_req = 0;
        sample(); chk("sf_ack_c3", if_ack_o, 0); advance();

        // data write with two wait states
        dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234; mem_ready = 0; mem_rdata = 16'hDEAD;
        cyc();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) mem_ready = 1;
            sample();
            chk("dw_req", mem_req_o, 1); chk("dw_addr", mem_addr_o, 16'h0200);
            chk("dw_we", mem_we_o, 1); chk("dw_wdata", mem_wdata_o, 16'h1234); chk("dw_ack_early", dm_ack_o, 0);
            advance();
        end
        sample(); chk("dw_ack", dm_ack_o, 1); chk("dw_req_done", mem_req_o, 0);
        chk("dw_rdata_kept", dm_rdata_o, 16'h0000); advance();
        dm_req = 0; dm_we = 0;

        // stale request held through its ack cycle
        dm_req = 1; dm_addr = 16'h0300; mem_ready = 1; mem_rdata = 16'h5555;
        cyc(); cyc();
        sample(); chk("st_ack", dm_ack_o, 1); chk("st_rdata", dm_rdata_o, 16'h5555); advance();
        sample(); chk("st_no_regrant", mem_req_o, 0); chk("st_ack_once", dm_ack_o, 0); advance();
        sample(); chk("st_regrant", mem_req_o, 1); chk("st_addr", mem_addr_o, 16'h0300); advance();
        sample(); chk("st_ack2", dm_ack_o, 1); advance();
        dm_req = 0;
        cyc();

        // flush while the fetch is on the bus
        if_req = 1; if_addr = 16'h0040; mem_ready = 0; mem_rdata = 16'hBEEF;
        cyc(); cyc();
        if_flush = 1; cyc();
        if_flush = 0; if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 16'h0500; cyc();
        mem_ready = 1;
        sample(); chk("fl_req_c4", mem_req_o, 1); chk("fl_addr_c4", mem_addr_o, 16'h0040); advance();
        mem_rdata = 16'h6666;
        sample(); chk("fl_no_ack", if_ack_o, 0); chk("fl_rdata_kept", if_rdata_o, 16'hA5A5);
        chk("fl_req_c5", mem_req_o, 0); advance();
        sample(); chk("fl_dm_grant", mem_req_o, 1); chk("fl_dm_addr", mem_addr_o, 16'h0500); advance();
        sample(); chk("fl_dm_ack", dm_ack_o, 1); chk("fl_dm_rdata", dm_rdata_o, 16'h6666); advance();
        dm_req = 0;
        cyc();

        // contention; fetch flushed in DM ack cycles so data can win repeatedly
        gq.delete();
        if_req = 1; if_addr = 16'h1000; dm_req = 1; dm_we = 0; dm_addr = 16'h2000;
        mem_ready = 1; mem_rdata = 16'h7777;
        for (int c = 0; c < 31; c++) begin
            if_flush = m_dma;
            cyc();
        end
        if_req = 0; dm_req = 0; if_flush = 0;
        chk("cont_count", gq.size(), 11);
        for (int k = 0; k < 11; k++) begin
            if (k < gq.size()) chk("cont_grant", gq[k], exp_g[k]);
        end
        cyc(); cyc();

        // reset in the middle of a data transfer
        dm_req = 1; dm_we = 1; dm_addr = 16'h0600; dm_wdata = 16'hCAFE; mem_ready = 0;
        cyc();
        sample(); chk("rm_req_before", mem_req_o, 1); advance();
        #1; rst_n = 0; #1;
        chk("rm_mem_req", mem_req_o, 0);
        chk("rm_mem_we", mem_we_o, 0);
        chk("rm_mem_addr", mem_addr_o, 0);
        chk("rm_if_ack", if_ack_o, 0);
        chk("rm_dm_ack", dm_ack_o, 0);
        chk("rm_if_rdata", if_rdata_o, 0);
        chk("rm_dm_rdata", dm_rdata_o, 0);
        dm_req = 0; dm_we = 0; model_reset(); prev_req = 0;
        #4; rst_n = 1;
        @(posedge clk); #1;
        if_req = 1; if_addr = 16'h0070; mem_ready = 1; mem_rdata = 16'h0F0F;
        cyc();
        sample(); chk("rm_if_req", mem_req_o, 1); chk("rm_if_addr", mem_addr_o, 16'h0070); advance();
        sample(); chk("rm_if_ack", if_ack_o, 1); chk("rm_if_rdata", if_rdata_o, 16'h0F0F); advance();
        if_req = 0;
        cyc();

        // random protocol-legal traffic
        for (int c = 0; c < 400; c++) begin
            sample();
            ifa_now = m_ifa; dma_now = m_dma; fl_now = if_flush;
            advance();
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = 16'($urandom);
            if_flush  = ($urandom_range(0, 9) == 0);
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = 16'($urandom); end
            end else if (ifa_now || fl_now) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom);
            end
            if (!dm_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                    dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
                end
            end else if (dma_now) begin
                dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
                dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            end
        end
        if_req = 0; dm_req = 0; if_flush = 0; mem_ready = 1;
        for (int c = 0; c < 6; c++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
